line_window_buffer: RTL
=======================

# line_window_buffer

Streaming 3x3 neighbourhood generator between the image source and the Sobel stage. Accepts one 8-bit grayscale pixel per handshake in raster order for a WIDTH x DEPTH frame, holds the two previous image rows in line delays, and emits one 3x3 window per interior pixel with a valid/ready handshake. The Sobel kernel then consumes a pixel stream instead of a whole flattened frame.

## Interface
- WIDTH, 640, pixels per row; must be >= 3.
- DEPTH, 480, rows per frame; must be >= 3.
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel present on in_pixel.
- in_ready  out  1  block can accept a pixel this cycle.
- in_pixel  in  8  grayscale pixel, raster order, row 0 col 0 first.
- out_valid  out  1  out_window holds a valid window.
- out_ready  in  1  downstream accepts the window this cycle.
- out_window  out  72  3x3 window; byte k = out_window[8k+7:8k], k = 3*r + c, with r=0 the oldest row and c=0 the leftmost column.
- out_last  out  1  asserted with the final window of a frame.

## Operation
- Input accept: in_valid && in_ready. Output accept: out_valid && out_ready.
- Position counters col (0..WIDTH-1) and row (0..DEPTH-1) advance on every input accept. col wraps to 0 and increments row. At (DEPTH-1, WIDTH-1), both wrap to 0, and the next pixel is row 0 col 0 of a new frame. There is no frame-start input.
- Line delays: two WIDTH-deep 8-bit delays in series. The tap after the first delay is the pixel one row above. The tap after the second delay is the pixel two rows above. Both shift only on input accept.
- Window register: three 3-byte column shift registers fed by {row-2 tap, row-1 tap, in_pixel}. They shift on input accept.
- Window valid rule: an accept at position (row, col) with row >= 2 and col >= 2 produces the window centred on (row-1, col-1). Other accepts produce no window. A full frame therefore produces (WIDTH-2)*(DEPTH-2) windows.
- out_last is set when the window is produced by the accept at (DEPTH-1, WIDTH-1).
- Windows never span frames. Line-delay contents from the previous frame are only exposed at rows 0-1, where windows are suppressed.
- Backpressure: in_ready = !out_valid || out_ready, which gives zero bubbles at full throughput. While out_valid && !out_ready, out_window and out_last are held stable and nothing shifts.
- Width rules: pixel data is 8 bits unsigned, passed through unchanged. Counters are $clog2(WIDTH) and $clog2(DEPTH) bits.

## Timing
- Latency: out_valid rises on the clock edge that accepts the pixel completing the window, so the window is visible one cycle later.
- Sustained throughput: 1 pixel/cycle when out_ready is held high.
- Reset (asynchronous, immediate on rst_n low):
  - out_valid = 0, out_last = 0, out_window = 0, col = 0, row = 0.
  - in_ready is 1 during and after reset.
  - Line-delay storage is not reset.
- Reset mid-frame discards the partial frame and any pending window. The first pixel after rst_n deasserts is row 0 col 0.
- Simultaneous output accept and new window-producing input accept in the same cycle: out_valid stays 1 and the window updates.
- Output accept with an input accept that produces no window (or no input accept): out_valid falls to 0.

## Structure
- Shared package edge_pkg:
  - PIX_W = 8 and WIN_W = 9*PIX_W.
  - A window-byte index function win_idx(r, c) = 3*r + c, also used by sobel.
- Sub-module line_delay #(DEPTH_PX, PIX_W): enable-gated fixed-length shift delay (register or RAM plus pointer). It is instantiated twice.
- Top logic holds the counters, window shift registers, and handshake.

## Test plan
- WIDTH=5, DEPTH=4, pixel = 10*row + col, out_ready=1, continuous in_valid:
  - The first window follows the accept of pixel 22 and has bytes k0..k8 = 0,1,2,10,11,12,20,21,22.
  - Exactly 6 windows are produced, and the last has bytes 12,13,14,22,23,24,32,33,34 with out_last=1.
- Same frame, out_ready held low for 3 cycles after the first window:
  - in_ready=0, and out_window and out_last stay stable.
  - After release, the remaining 5 windows follow with none lost or duplicated.
- Two back-to-back frames, second frame pixel = 100 + 10*row + col:
  - No window is produced before the second frame's pixel (2,2).
  - That window's bytes are 100,101,102,110,111,112,120,121,122.
- Random in_valid gaps and random out_ready: the window sequence matches a reference model exactly, and throughput is 1/cycle when both are high.
- rst_n pulsed low after 13 accepted pixels while out_valid=1:
  - out_valid and out_last go to 0 immediately.
  - A following full frame yields exactly 6 correct windows.
- WIDTH=3, DEPTH=3: exactly one window, with out_last=1 and bytes equal to the 9 inputs in order.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection pipeline: pixel/window widths and
// the 3x3 window byte layout used by both the line window buffer and sobel.
package edge_pkg;

   localparam int PIX_W = 8;
   localparam int WIN_W = 9 * PIX_W;

   typedef logic [PIX_W-1:0] pixel_t;
   typedef logic [WIN_W-1:0] window_t;

   // Byte slot of window element (r, c); r=0 is the oldest row, c=0 the leftmost column.
   function automatic int win_idx(input int r, input int c);
      return 3 * r + c;
   endfunction

endpackage

// File: rtl/line_window_buffer_if.sv
// Pixel-in / window-out stream bundle for line_window_buffer.
// The slave modport is the buffer itself; master is its environment.
interface line_window_buffer_if;
   import edge_pkg::*;

   logic    in_valid;
   logic    in_ready;
   pixel_t  in_pixel;
   logic    out_valid;
   logic    out_ready;
   window_t out_window;
   logic    out_last;

   modport slave (
      input  in_valid,
      input  in_pixel,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_window,
      output out_last
   );

   modport master (
      output in_valid,
      output in_pixel,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_window,
      input  out_last
   );

endinterface

// File: rtl/line_delay.sv
// Enable-gated fixed-length pixel delay: dout is the value written DEPTH_PX
// enabled cycles earlier. Circular buffer plus write pointer; storage is not reset.
module line_delay #(
   parameter int DEPTH_PX = 640,
   parameter int PIX_W    = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [PIX_W-1:0] din,
   output logic [PIX_W-1:0] dout
);

   localparam int PTR_W = (DEPTH_PX > 1) ? $clog2(DEPTH_PX) : 1;
   localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH_PX - 1);

   logic [PIX_W-1:0] mem_q [DEPTH_PX];
   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Read-before-write at the same slot yields the oldest stored sample.
   assign dout = mem_q[ptr_q];

   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = (ptr_q == PTR_MAX) ? '0 : ptr_q + PTR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (en) begin
         mem_q[ptr_q] <= din;
      end
   end

endmodule

// File: rtl/line_window_buffer.sv
// Streaming 3x3 neighbourhood generator: two line delays feed a 3-column shift
// window; one window is emitted per interior pixel with valid/ready backpressure.
module line_window_buffer
   import edge_pkg::*;
#(
   parameter int WIDTH = 640,
   parameter int DEPTH = 480
) (
   input  logic                 clk,
   input  logic                 rst_n,
   line_window_buffer_if.slave  bus
);

   localparam int COL_W = $clog2(WIDTH);
   localparam int ROW_W = $clog2(DEPTH);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(DEPTH - 1);

   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   // Indexed [column][row]; column 2 is the newest, row 2 is the current image row.
   logic [2:0][2:0][PIX_W-1:0] win_q, win_d;
   logic    out_valid_q, out_valid_d;
   logic    out_last_q, out_last_d;
   logic    in_ready;
   logic    in_accept;
   pixel_t  tap_row1;
   pixel_t  tap_row2;
   window_t window_flat;

   assign in_ready  = !out_valid_q || bus.out_ready;
   assign in_accept = bus.in_valid && in_ready;

   line_delay #(
      .DEPTH_PX (WIDTH),
      .PIX_W    (PIX_W)
   ) u_delay_row1 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_accept),
      .din   (bus.in_pixel),
      .dout  (tap_row1)
   );

   line_delay #(
      .DEPTH_PX (WIDTH),
      .PIX_W    (PIX_W)
   ) u_delay_row2 (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (in_accept),
      .din   (tap_row1),
      .dout  (tap_row2)
   );

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      win_d       = win_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      if (in_accept) begin
         col_d = (col_q == COL_MAX) ? '0 : col_q + COL_W'(1);
         if (col_q == COL_MAX) begin
            row_d = (row_q == ROW_MAX) ? '0 : row_q + ROW_W'(1);
         end
         win_d[0]    = win_q[1];
         win_d[1]    = win_q[2];
         win_d[2]    = {bus.in_pixel, tap_row1, tap_row2};
         // Rows 0-1 and columns 0-1 would expose stale line data or wrap across rows.
         out_valid_d = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
         out_last_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   always_comb begin
      window_flat = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            window_flat[win_idx(r, c)*PIX_W +: PIX_W] = win_q[c][r];
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_last   = out_last_q;
   assign bus.out_window = window_flat;

endmodule
